// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;
    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN          = 2'b00,
        ST_MISS         = 2'b01,
        ST_MISS_DISCARD = 2'b10
    } fetch_state_e;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: enable holds the contents, clear loads a bubble.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int          W         = XLEN,
    parameter logic [31:0] BUBBLE_IN = NOP_INSTR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [31:0]  instr_in,
    input  logic [W-1:0] pc_plus4_in,
    output logic [31:0]  instr_out,
    output logic [W-1:0] pc_plus4_out,
    output logic         valid_out
);
    logic [31:0]  instr_q,    instr_d;
    logic [W-1:0] pc_plus4_q, pc_plus4_d;
    logic         valid_q,    valid_d;

    // A clear only lands when enabled, so a stall always wins over a bubble.
    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (en) begin
            if (clr) begin
                instr_d    = BUBBLE_IN;
                pc_plus4_d = '0;
                valid_d    = 1'b0;
            end else begin
                instr_d    = instr_in;
                pc_plus4_d = pc_plus4_in;
                valid_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q    <= BUBBLE_IN;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_out    = instr_q;
    assign pc_plus4_out = pc_plus4_q;
    assign valid_out    = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, variable-latency imem handshake, redirect handling, IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int               XLEN_P    = XLEN,
    parameter logic [XLEN_P-1:0] RESET_PC = '0,
    parameter logic [31:0]      NOP_I     = NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic              redirect_id,
    input  logic [XLEN_P-1:0] redirect_target_id,
    output logic              imem_req,
    output logic [XLEN_P-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic [31:0]       instr_id,
    output logic [XLEN_P-1:0] pc_plus4_id,
    output logic              valid_id,
    output logic              fetch_busy
);
    fetch_state_e      state_q, state_d;
    logic [XLEN_P-1:0] pc_q,    pc_d;
    logic [XLEN_P-1:0] tgt_q,   tgt_d;
    logic              ifid_clr;
    logic              redir_ok;
    logic [XLEN_P-1:0] redir_tgt;
    logic [XLEN_P-1:0] pc_plus4;

    assign redir_ok  = redirect_id & ~stall_id;
    assign redir_tgt = redirect_target_id & ~XLEN_P'(3);
    assign pc_plus4  = pc_q + XLEN_P'(4);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        ifid_clr = 1'b1;
        unique case (state_q)
            ST_RUN, ST_MISS: begin
                if (imem_ready) begin
                    state_d = ST_RUN;
                    if (redir_ok) begin
                        pc_d = redir_tgt;
                    end else if (!stall_if) begin
                        pc_d     = pc_plus4;
                        ifid_clr = 1'b0;
                    end
                end else if (redir_ok) begin
                    // Request still in flight: remember where to go once it retires.
                    tgt_d   = redir_tgt;
                    state_d = ST_MISS_DISCARD;
                end else begin
                    state_d = ST_MISS;
                end
            end
            ST_MISS_DISCARD: begin
                if (redir_ok) tgt_d = redir_tgt;
                if (imem_ready) begin
                    pc_d    = redir_ok ? redir_tgt : tgt_q;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    if_id_reg #(.W(XLEN_P), .BUBBLE_IN(NOP_I)) u_if_id (
        .clk          (clk),
        .rst          (rst),
        .en           (~stall_id),
        .clr          (ifid_clr),
        .instr_in     (imem_rdata),
        .pc_plus4_in  (pc_plus4),
        .instr_out    (instr_id),
        .pc_plus4_out (pc_plus4_id),
        .valid_out    (valid_id)
    );

    assign imem_req   = ~rst;
    assign imem_addr  = pc_q;
    assign fetch_busy = (state_q == ST_MISS) || (state_q == ST_MISS_DISCARD);
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register.
- Sits directly upstream of the hazard unit and decode.
- Holds the PC and honours stall_if/stall_id from the hazard unit.
- Redirects on branch/jump resolved in ID and handshakes with a variable-latency instruction memory, inserting bubbles while waiting.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word injected as a bubble (sll $0,$0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
stall_if  in  1  from hazard unit; hold PC
stall_id  in  1  from hazard unit; hold IF/ID register
redirect_id  in  1  branch taken or jump resolved in ID
redirect_target_id  in  XLEN  target PC for redirect
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address (word aligned)
imem_rdata  in  32  instruction word, valid when imem_ready
imem_ready  in  1  request accepted/data valid this cycle
instr_id  out  32  IF/ID instruction
pc_plus4_id  out  XLEN  IF/ID PC+4
valid_id  out  1  IF/ID holds a real instruction
fetch_busy  out  1  high in MISS or MISS_DISCARD

Behaviour:
- Reset (asynchronous, any state):
  - pc=RESET_PC, state=RUN, instr_id=NOP_INSTR, pc_plus4_id=0, valid_id=0, pending target=0.
  - imem_req=0 while rst high; imem_req=1 from the first cycle after release.
- imem_addr=pc at all times. imem_addr must stay stable while imem_req && !imem_ready.
- redirect_id is accepted only when stall_id=0. Under stall_id it is ignored; the hazard unit holds the branch in ID and it re-presents next cycle.
- State RUN:
  - imem_ready=1, stall_if=0, no redirect: pc<=pc+4. IF/ID loads {imem_rdata, pc+4, valid=1} unless stall_id.
  - imem_ready=1, accepted redirect: pc<=redirect_target_id. IF/ID loads bubble (NOP, valid=0). The fetched word is discarded.
  - imem_ready=1, stall_if=1: pc holds. The word is dropped and refetched next cycle (reads are idempotent). IF/ID holds if stall_id, else loads a bubble.
  - imem_ready=0: go MISS; pc holds. IF/ID loads bubble unless stall_id (hold). An accepted redirect this cycle latches the target and goes MISS_DISCARD.
- State MISS (request outstanding, address frozen):
  - IF/ID bubble each cycle unless stall_id (hold).
  - Accepted redirect: latch target, go MISS_DISCARD.
  - imem_ready=1 and stall_if=0: behave as the RUN ready case (pc+4, load word), go RUN.
  - imem_ready=1 and stall_if=1: drop the word, go RUN, pc unchanged.
- State MISS_DISCARD:
  - IF/ID bubble unless stall_id.
  - A further accepted redirect overwrites the latched target.
  - On imem_ready: discard data, pc<=latched target, go RUN.
- pc arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0.
- redirect_target_id[1:0] is ignored and forced to 00.
- Simultaneous stall_id with a bubble request: stall wins (IF/ID holds).
- IF/ID clear from a redirect is synchronous; it takes effect on the same edge that loads the new pc.

Decomposition:
- Shared package: XLEN, NOP_INSTR, fetch FSM state enum (RUN, MISS, MISS_DISCARD), 2-bit encoding.
- Sub-module if_id_reg: instr/pc_plus4/valid register with en (=!stall_id), clr (bubble) and asynchronous reset. Reused pattern for later stage registers.

Test Plan:
- Reset release, imem_ready tied 1 → imem_addr 0,4,8,12 on consecutive cycles; valid_id rises 1 cycle after the first fetch; instr_id tracks imem_rdata one cycle late.
- stall_if=stall_id=1 for 2 cycles at pc=0x10 → imem_addr stays 0x10; instr_id/pc_plus4_id frozen; resumes 0x14 after release.
- redirect_id=1, target 0x40, at pc=0x20, no stall → next imem_addr 0x40; IF/ID shows valid_id=0 for one cycle; word from 0x20 never appears.
- imem_ready low 3 cycles at 0x08 → fetch_busy=1, addr frozen at 0x08, 3 bubbles then instr from 0x08 with valid_id=1.
- During the miss, redirect to 0x80 → word from 0x08 discarded; next address 0x80; valid_id stays 0 until 0x80 data arrives.
- redirect_id with stall_id=1 → ignored, pc unchanged; asserting rst mid-MISS → pc=RESET_PC, valid_id=0 immediately, state RUN.
